// File: rtl/rfile_sb.sv
// rfile_sb: 2-read / 2-write register file with optional write-to-read
// bypass and a per-register busy scoreboard that raises read hazards.
// Port 0 carries ALU writeback and port 1 carries load writeback.
// Register 0 always reads as zero.
module rfile_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned SP_IDX  = 7,
  parameter int unsigned SP_INIT = 255,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  ra1,
  input  logic [REG_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we0,
  input  logic [REG_W-1:0]  wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [REG_W-1:0]  wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_v,
  input  logic [REG_W-1:0]  iss_a,
  input  logic              clr,
  output logic              hz1,
  output logic              hz2,
  output logic              waw_err
);

  localparam int unsigned       NREG   = 1 << REG_W;
  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic              r_waw;

  logic [NREG-1:0]   w_busy_nxt;
  logic              w_waw_set;
  logic              w_iss_hit;
  logic              w_cov1;
  logic              w_cov2;

  // Register storage: async reset to zero / SP_INIT; port 1 has priority on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[REG_W'(i)] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else begin
      if (we0 && wa0 != '0) r_regs[wa0] <= wd0;
      if (we1 && wa1 != '0) r_regs[wa1] <= wd1;
    end
  end

  // Next busy vector: writes clear, issue sets (set beats clear), clr beats everything.
  always_comb begin
    w_busy_nxt = r_busy;
    w_waw_set  = 1'b0;
    w_iss_hit  = (we0 && wa0 == iss_a) || (we1 && wa1 == iss_a);
    if (we0 && wa0 != '0) w_busy_nxt[wa0] = 1'b0;
    if (we1 && wa1 != '0) w_busy_nxt[wa1] = 1'b0;
    if (clr) begin
      w_busy_nxt = '0;
    end else if (iss_v && iss_a != '0) begin
      w_busy_nxt[iss_a] = 1'b1;
      w_waw_set         = r_busy[iss_a] && !w_iss_hit;
    end
  end

  // Scoreboard state and sticky WAW error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_waw  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_waw  <= r_waw | w_waw_set;
    end
  end

  // Read port 1: optional same-cycle forwarding, port 1 write data first.
  always_comb begin
    rd1 = r_regs[ra1];
    if (BYPASS) begin
      if (we1 && wa1 == ra1)      rd1 = wd1;
      else if (we0 && wa0 == ra1) rd1 = wd0;
    end
    if (ra1 == '0) rd1 = '0;
  end

  // Read port 2: same forwarding rules as port 1.
  always_comb begin
    rd2 = r_regs[ra2];
    if (BYPASS) begin
      if (we1 && wa1 == ra2)      rd2 = wd1;
      else if (we0 && wa0 == ra2) rd2 = wd0;
    end
    if (ra2 == '0) rd2 = '0;
  end

  // Hazards: source busy and not covered by a forwarded write this cycle.
  always_comb begin
    w_cov1 = BYPASS && ((we0 && wa0 == ra1) || (we1 && wa1 == ra1));
    w_cov2 = BYPASS && ((we0 && wa0 == ra2) || (we1 && wa1 == ra2));
    hz1    = (ra1 != '0) && r_busy[ra1] && !w_cov1;
    hz2    = (ra2 != '0) && r_busy[ra2] && !w_cov2;
  end

  assign waw_err = r_waw;

endmodule

// File: doc/rfile_sb.md
Name: rfile_sb

Overview:
- Parametrised successor of the 2R/1W processor register file.
- 2 read ports and 2 write ports: port 0 for ALU writeback, port 1 for load writeback.
- Adds optional write-to-read bypass and a per-register busy scoreboard that drives hazard flags for the pipelined core's stall logic.
- Sits between decode (read and issue) and writeback.

Parameters:
DATA_W, 16, data word width in bits
REG_W, 3, register address width; NREG = 2**REG_W registers
SP_IDX, 7, index of stack-pointer register
SP_INIT, 255, reset value of register SP_IDX (truncated to DATA_W)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
ra1  in  REG_W  read address port 1
ra2  in  REG_W  read address port 2
rd1  out  DATA_W  read data port 1 (combinational)
rd2  out  DATA_W  read data port 2 (combinational)
we0  in  1  write enable, port 0
wa0  in  REG_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
wa1  in  REG_W  write address, port 1
wd1  in  DATA_W  write data, port 1
iss_v  in  1  instruction issued with destination register
iss_a  in  REG_W  issued destination register
clr  in  1  synchronous flush of all busy bits
hz1  out  1  read port 1 source pending (stall)
hz2  out  1  read port 2 source pending (stall)
waw_err  out  1  sticky: issue to an already-busy register

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers 0, except reg[SP_IDX] = SP_INIT.
  - busy[] all 0; waw_err 0.
  - Outputs: rd1/rd2 = stored values (0 or SP_INIT); hz1/hz2 = 0.
- Register 0 hardwired zero:
  - Reads of address 0 return 0; hz for address 0 always 0.
  - Writes to 0 ignored; issue to 0 never sets busy and never sets waw_err.
- Writes:
  - At posedge, reg[waK] <= wdK when weK and waK != 0.
  - we0 and we1 to the same address: port 1 wins.
- Reads: combinational, zero latency.
  - BYPASS=1, ra != 0: if we1 && wa1 == ra, rd = wd1; else if we0 && wa0 == ra, rd = wd0; else rd = reg[ra].
  - BYPASS=0: rd = reg[ra]; new data visible the cycle after the write edge.
- Scoreboard (busy[NREG], updated at posedge):
  - Write on port K with waK != 0 clears busy[waK].
  - iss_v with iss_a != 0 sets busy[iss_a].
  - Set and clear to the same address in the same cycle: set wins (a new producer is outstanding).
  - clr: all busy bits <= 0; an iss_v in the same cycle is cancelled (clr wins). clr does not modify register contents.
  - iss_v to a register already busy, with no same-cycle clearing write: waw_err <= 1 (sticky until reset); busy stays 1.
- Hazards (combinational):
  - hzN = (raN != 0) && busy[raN] && !cover.
  - cover = BYPASS && ((we0 && wa0 == raN) || (we1 && wa1 == raN)).
  - BYPASS=0: cover = 0, so the stall persists through the write cycle and drops the next cycle.
- Reset asserted mid-operation: state forced to reset values immediately, independent of clk. Pending issues are lost; hz drops at once.

Test Plan:
- Reset release -> rd1 with ra1=7 reads 255; ra2=3 reads 0; hz1=hz2=0; waw_err=0.
- we0=1, wa0=3, wd0=0x1234, ra1=3, BYPASS=1 -> rd1=0x1234 same cycle. With BYPASS=0 -> rd1=0 that cycle, 0x1234 next cycle.
- we0 and we1 both to reg 5 (wd0=0xAAAA, wd1=0x5555) -> reg5=0x5555 after edge; bypassed read gives 0x5555. Write to reg 0 -> reg0 reads 0.
- iss_v, iss_a=4; next cycle ra1=4 -> hz1=1. Then we1, wa1=4: BYPASS=1 gives hz1=0 that cycle with rd1=wd1; BYPASS=0 gives hz1=1 that cycle, 0 next.
- Same-cycle iss_a=6 and we0 wa0=6 -> busy[6]=1 after edge. Second issue to 6 with no write -> waw_err=1, holding until reset.
- iss_a=2 busy, then clr with iss_v iss_a=3 -> busy[2]=busy[3]=0, hz=0. Assert rst_n low mid-cycle -> reg values and busy reset without clock edge.
